// File: rtl/t05_pkg.sv
// Shared types and codes for the Huffman merge write-back block.
package t05_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StCheck,
        StWipe1,
        StWipe2,
        StWrSum,
        StWrTree,
        StDone,
        StRoot,
        StErr
    } state_e;

    localparam logic [8:0]  HIST_INT_BASE = 9'd256;
    localparam int unsigned MAX_NODES     = 128;

    localparam logic [3:0]  EN_MERGE  = 4'd3;

    localparam logic [2:0]  FIN_IDLE  = 3'd0;
    localparam logic [2:0]  FIN_MERGE = 3'd3;
    localparam logic [2:0]  FIN_TREE  = 3'd4;
    localparam logic [2:0]  FIN_ERR   = 3'd5;

endpackage

// File: rtl/t05_merge_nodes.sv
// Huffman tree write-back: wipes the two merged nodes, stores their summed count in the
// next internal-node slot and records the parent/child link in tree memory.
module t05_merge_nodes #(
    parameter int unsigned MAX_NODES = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  en_state,
    input  logic [8:0]  least1,
    input  logic [8:0]  least2,
    input  logic [63:0] sum,
    output logic        hist_wr,
    output logic [8:0]  hist_addr,
    output logic [63:0] hist_wdata,
    input  logic        hist_ack,
    output logic        tree_wr,
    output logic [6:0]  tree_addr,
    output logic [17:0] tree_wdata,
    input  logic        tree_ack,
    output logic [7:0]  node_cnt,
    output logic [8:0]  root,
    output logic        tree_done,
    output logic        err,
    output logic [2:0]  fin_state
);
    import t05_pkg::*;

    state_e      state_q, state_d;
    logic [8:0]  l1_q, l1_d;
    logic [8:0]  l2_q, l2_d;
    logic [63:0] sum_q, sum_d;
    logic [7:0]  node_cnt_q, node_cnt_d;
    logic [8:0]  root_q, root_d;
    logic        tree_done_q, tree_done_d;
    logic        err_q, err_d;
    logic        hist_wr_q, hist_wr_d;
    logic [8:0]  hist_addr_q, hist_addr_d;
    logic [63:0] hist_wdata_q, hist_wdata_d;
    logic        tree_wr_q, tree_wr_d;
    logic [6:0]  tree_addr_q, tree_addr_d;
    logic [17:0] tree_wdata_q, tree_wdata_d;
    logic [2:0]  fin_q, fin_d;

    always_comb begin
        state_d     = state_q;
        l1_d        = l1_q;
        l2_d        = l2_q;
        sum_d       = sum_q;
        node_cnt_d  = node_cnt_q;
        root_d      = root_q;
        tree_done_d = tree_done_q;
        err_d       = err_q;

        unique case (state_q)
            StIdle: begin
                if (en_state == EN_MERGE) begin
                    l1_d    = least1;
                    l2_d    = least2;
                    sum_d   = sum;
                    state_d = StCheck;
                end
            end
            StCheck: begin
                // Identical picks mean the search found a single remaining node: the root.
                if (l1_q == l2_q) begin
                    root_d      = l1_q;
                    tree_done_d = 1'b1;
                    state_d     = StRoot;
                end else if (node_cnt_q == 8'(MAX_NODES)) begin
                    err_d   = 1'b1;
                    state_d = StErr;
                end else begin
                    state_d = StWipe1;
                end
            end
            StWipe1:  if (hist_ack) state_d = StWipe2;
            StWipe2:  if (hist_ack) state_d = StWrSum;
            StWrSum:  if (hist_ack) state_d = StWrTree;
            StWrTree: begin
                if (tree_ack) begin
                    state_d = StDone;
                    if (node_cnt_q != 8'(MAX_NODES)) node_cnt_d = node_cnt_q + 8'd1;
                end
            end
            StDone:   if (en_state != EN_MERGE) state_d = StIdle;
            StRoot, StErr: ;
            default:  state_d = StIdle;
        endcase

        // Outputs are decoded from the next state so they register in step with it.
        hist_wr_d    = 1'b0;
        hist_addr_d  = '0;
        hist_wdata_d = '0;
        tree_wr_d    = 1'b0;
        tree_addr_d  = '0;
        tree_wdata_d = '0;
        fin_d        = FIN_IDLE;
        case (state_d)
            StWipe1: begin
                hist_wr_d   = 1'b1;
                hist_addr_d = l1_d;
            end
            StWipe2: begin
                hist_wr_d   = 1'b1;
                hist_addr_d = l2_d;
            end
            StWrSum: begin
                hist_wr_d    = 1'b1;
                hist_addr_d  = HIST_INT_BASE + {2'b00, node_cnt_d[6:0]};
                hist_wdata_d = sum_d;
            end
            StWrTree: begin
                tree_wr_d    = 1'b1;
                tree_addr_d  = node_cnt_d[6:0];
                tree_wdata_d = {l1_d, l2_d};
            end
            StDone:  fin_d = FIN_MERGE;
            StRoot:  fin_d = FIN_TREE;
            StErr:   fin_d = FIN_ERR;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            l1_q         <= '0;
            l2_q         <= '0;
            sum_q        <= '0;
            node_cnt_q   <= '0;
            root_q       <= '0;
            tree_done_q  <= 1'b0;
            err_q        <= 1'b0;
            hist_wr_q    <= 1'b0;
            hist_addr_q  <= '0;
            hist_wdata_q <= '0;
            tree_wr_q    <= 1'b0;
            tree_addr_q  <= '0;
            tree_wdata_q <= '0;
            fin_q        <= FIN_IDLE;
        end else begin
            state_q      <= state_d;
            l1_q         <= l1_d;
            l2_q         <= l2_d;
            sum_q        <= sum_d;
            node_cnt_q   <= node_cnt_d;
            root_q       <= root_d;
            tree_done_q  <= tree_done_d;
            err_q        <= err_d;
            hist_wr_q    <= hist_wr_d;
            hist_addr_q  <= hist_addr_d;
            hist_wdata_q <= hist_wdata_d;
            tree_wr_q    <= tree_wr_d;
            tree_addr_q  <= tree_addr_d;
            tree_wdata_q <= tree_wdata_d;
            fin_q        <= fin_d;
        end
    end

    assign hist_wr    = hist_wr_q;
    assign hist_addr  = hist_addr_q;
    assign hist_wdata = hist_wdata_q;
    assign tree_wr    = tree_wr_q;
    assign tree_addr  = tree_addr_q;
    assign tree_wdata = tree_wdata_q;
    assign node_cnt   = node_cnt_q;
    assign root       = root_q;
    assign tree_done  = tree_done_q;
    assign err        = err_q;
    assign fin_state  = fin_q;

endmodule

// File: doc/t05_merge_nodes.md
# t05_merge_nodes

Write-back half of the Huffman tree build. After the least-value search returns the two cheapest nodes and their summed count, this block removes both nodes from the histogram and writes the merged count into the next free internal-node slot. It then records the parent/child link in tree memory and reports completion to the top-level controller through `fin_state`. It runs while the controller holds `en_state == 3`, between successive least-value scans.

## Interface
Parameters:
- `MAX_NODES`, default 128: number of internal-node slots, at histogram addresses 256..383.

Ports:
- `clk`: input, 1 bit. Clock.
- `rst`: input, 1 bit. Reset; asynchronous, active-high.
- `en_state`: input, 4 bits. Controller state; block arms on value 3.
- `least1`, `least2`: input, 9 bits each. Chosen nodes; bit8=1 means internal node, [7:0] is the index. Each value is directly its histogram address.
- `sum`: input, 64 bits. Combined count of `least1` and `least2`.
- `hist_wr`: output, 1 bit. Histogram write request.
- `hist_addr`: output, 9 bits. Histogram write address.
- `hist_wdata`: output, 64 bits. Histogram write data.
- `hist_ack`: input, 1 bit. Histogram write accepted.
- `tree_wr`: output, 1 bit. Tree-memory write request.
- `tree_addr`: output, 7 bits. Internal-node index.
- `tree_wdata`: output, 18 bits. {`least1`, `least2`}; `least1` is the left child.
- `tree_ack`: input, 1 bit. Tree write accepted.
- `node_cnt`: output, 8 bits. Internal nodes created so far (0..128).
- `root`: output, 9 bits. Final root node, valid once `tree_done` is set.
- `tree_done`: output, 1 bit. Sticky: tree complete.
- `err`: output, 1 bit. Sticky: node-slot overflow.
- `fin_state`: output, 3 bits. 0 = busy/idle; 3 = merge done; 4 = tree complete; 5 = overflow error.

## Operation
- **States:** IDLE, CHECK, WIPE1, WIPE2, WRSUM, WRTREE, DONE, ROOT, ERR.
- **IDLE:** if `en_state == 3`, latch `least1`, `least2` and `sum` into internal registers, then go to CHECK. Inputs are not sampled again until the next arm.
- **CHECK:**
  - `least1 == least2` means only one node remains: set `root = least1` and `tree_done = 1`, go to ROOT.
  - Otherwise, if `node_cnt == MAX_NODES`: set `err = 1`, go to ERR.
  - Otherwise go to WIPE1.
- **WIPE1:** write 0 to histogram address `least1`.
- **WIPE2:** write 0 to histogram address `least2`.
- **WRSUM:** write `sum` to histogram address `256 + node_cnt`, i.e. {1'b1, `node_cnt[6:0]`}.
- **WRTREE:** write {`least1`, `least2`} to tree address `node_cnt[6:0]`. Increment `node_cnt` on exit.
- **Write handshake:**
  - Request, address and data are held stable while in the state.
  - The state advances on the clock edge where the matching ack is sampled high.
  - The request drops in the next state. Ack outside a request is ignored.
- **DONE, ROOT, ERR:** drive `fin_state` to 3, 4 or 5 respectively.
  - DONE returns to IDLE on the first cycle with `en_state != 3`, so one arm produces exactly one merge.
  - ROOT and ERR are terminal until `rst`.
- **No abort:** `en_state` is ignored in CHECK through WRTREE. A started sequence always completes, so the histogram and tree are never left half-written.
- **Width rules:** `sum` is passed through unchanged; there is no arithmetic on it. `node_cnt` saturates at 128 and never wraps.

## Timing
- **Reset values:** all outputs 0, `root` = 0, `node_cnt` = 0, state IDLE.
- **Reset mid-sequence:** requests deassert immediately (asynchronous), and no partial state survives.
- **Latency with acks tied high:**
  - Arm cycle N; CHECK at N+1; WIPE1..WRTREE at N+2..N+5.
  - `fin_state = 3` from N+6.
  - Each cycle of ack-low adds one cycle of stall.
- **Root/error path:** `fin_state = 4` or `5` from N+2.
- **`node_cnt`:** the new value is visible in the same cycle `fin_state` first reads 3.
- **Simultaneous events:** `rst` overrides everything.

## Structure
- Shared package `t05_pkg` holds:
  - the state enum;
  - `HIST_INT_BASE = 9'd256`;
  - `MAX_NODES = 128`;
  - the `en_state` code `EN_MERGE = 3`;
  - the `fin_state` codes `FIN_MERGE = 3`, `FIN_TREE = 4`, `FIN_ERR = 5`.
- No sub-module. Both write ports share one state-indexed mux and one handshake rule, which stays inline.

## Test plan
- **Single merge:** `least1 = 9'h041`, `least2 = 9'h042`, `sum = 7`, acks tied high, `en_state = 3` at cycle N.
  - Histogram writes, in order: (0x041, 0), (0x042, 0), (0x100, 7).
  - Tree write: (0, {0x041, 0x042}).
  - `fin_state = 3` at N+6; `node_cnt = 1`.
- **Backpressure:** hold `hist_ack` low 3 cycles during WIPE2.
  - Address/data stay at (0x042, 0) throughout.
  - `fin_state = 3` at N+9.
- **Re-arm guard:** keep `en_state = 3` for 20 cycles after DONE → exactly one merge occurs. Drop `en_state` to 0 and raise it again → a second merge writes to histogram 0x101 and tree address 1.
- **Root:** `least1 = least2 = 9'h105` → no writes; `fin_state = 4` at N+2; `root = 0x105`; `tree_done = 1`.
- **Overflow:** perform 128 merges, then arm again → no writes; `err = 1`; `fin_state = 5`; `node_cnt` stays 128.
- **Reset mid-sequence:** assert `rst` during WRSUM → `hist_wr` drops the same cycle; `node_cnt = 0`; IDLE afterwards.
